fcb_cfg_receiver: RTL and testbench
===================================

# fcb_cfg_receiver

Fabric-side endpoint of the FCB serial configuration chain. Accepts the bitstream that the FCB shifts out one bit per strobe, holds it in a CHAIN_LEN-bit shift chain, and presents the chain's last bit back as the tail for FCB readback. Computes an Adler-32 checksum over the received bytes. When the global configuration reset is released, it commits the chain into a shadow register that drives the fabric configuration bits.

## Interface
- CHAIN_LEN, 64: configuration chain length in bits; must be ≥ 8.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- cfg_head  in  1  serial data bit from FCB.
- cfg_shift  in  1  bit strobe; one bit is accepted per cycle in which it is high.
- cfg_greset  in  1  global configuration reset from FCB, active-high; a high-to-low transition commits the configuration.
- cfg_tail  out  1  chain MSB, registered; returned to FCB.
- cfg_bits  out  CHAIN_LEN  committed configuration (shadow register).
- cfg_valid  out  1  cfg_bits and cfg_checksum are valid.
- cfg_bit_count  out  32  bits accepted since LOAD entry; saturates at 32'hFFFFFFFF.
- cfg_checksum  out  32  {B[15:0], A[15:0]} Adler-32.

## Operation
- Reset values:
  - chain = 0, cfg_tail = 0, cfg_bits = 0, cfg_valid = 0.
  - cfg_bit_count = 0, byte shift register = 0, byte bit counter = 0.
  - A = 16'h0001, B = 0, cfg_checksum = 0.
  - state = IDLE.
- Shift behavior: in LOAD or ACTIVE, when cfg_shift is high, chain <= {chain[CHAIN_LEN-2:0], cfg_head}. cfg_tail always equals chain[CHAIN_LEN-1]. In IDLE and FOLD, cfg_shift is ignored.
- Byte assembly: runs in LOAD only. Each accepted bit shifts MSB-first into an 8-bit byte register and increments a 3-bit bit counter. When the counter wraps 7→0, the completed byte is folded into the checksum in the same cycle.
- Checksum fold with byte d:
  - A' = A + d; subtract 65521 if A' ≥ 65521.
  - B' = B + A'; subtract 65521 if B' ≥ 65521.
  - Each step uses one conditional subtract; no divider. Intermediate widths are 17 bits.
- Partial final byte: if the bit counter is k ≠ 0 at commit, the last k bits, right-aligned (d = byte_reg & ((1<<k)−1)), are folded exactly once in FOLD.
- States:
  - IDLE: go to LOAD when cfg_greset = 1.
  - LOAD: accept bits and update counters. On cfg_greset = 0, go to FOLD.
  - FOLD: one cycle. Fold the partial byte if k ≠ 0. Then cfg_bits <= chain, cfg_checksum <= {B, A} (after the fold), cfg_valid <= 1. Go to ACTIVE.
  - ACTIVE: shifts still move the chain and cfg_tail (readback path), but cfg_bits, cfg_checksum and counters are frozen. On cfg_greset = 1, go to LOAD with cfg_valid <= 0, A = 1, B = 0, counts cleared; chain is kept.
- Simultaneous events:
  - Shift and greset fall in the same LOAD cycle: the bit is accepted and counted, and it is included in both the commit and the fold.
  - Shift in the ACTIVE cycle where greset rises: the chain shifts, but the bit is not counted.
- Reset mid-operation forces all reset values immediately and discards any partial load.

## Timing
- cfg_tail reflects a shift one cycle after the cycle in which cfg_shift is high.
- cfg_valid rises 2 cycles after the first cycle in which cfg_greset is sampled low (LOAD→FOLD→ACTIVE).
- cfg_valid falls the cycle after cfg_greset is sampled high in ACTIVE.
- The block accepts one bit per cycle at full rate. There is no backpressure.

## Configuration
- CFG_CHAIN_CHECKSUM_EN defined: the Adler-32 logic, byte assembly and FOLD update are present as described above.
- CFG_CHAIN_CHECKSUM_EN undefined:
  - The checksum logic is removed and cfg_checksum is tied to 0.
  - FOLD still exists, so the cfg_valid timing is unchanged.
  - Chain, counters and cfg_bits behave identically.

## Test plan
- Reset with cfg_greset = 1, then shift 16 bits 0x0102 MSB-first, then drop cfg_greset → cfg_bit_count = 16, cfg_checksum = 32'h00060004, cfg_valid = 1 two cycles later.
- Shift 12 bits 0xABC, then drop greset → partial fold with k = 4, d = 0x0C, cfg_checksum = 32'h016400B8.
- Shift 257 bytes of 0xFF → A wraps via subtract, cfg_checksum[15:0] = 16'h000F.
- CHAIN_LEN = 64: shift 64 bits of a pattern, commit, then shift 64 more bits in ACTIVE → cfg_tail reproduces the original pattern MSB-first, and cfg_bits is unchanged.
- Drop greset in the same cycle as the 8th shift of 0x01 → byte folded once, cfg_checksum = 32'h00020002.
- Assert reset in LOAD after 20 bits → all outputs 0, state IDLE; with cfg_greset still high the block re-enters LOAD and a fresh load gives the correct checksum.

Source files
------------

// File: rtl/fcb_cfg_receiver_if.sv
// FCB serial configuration link: head/strobe/global-reset toward the fabric,
// tail back to the FCB for readback.
interface fcb_cfg_receiver_if;
  logic cfg_head;
  logic cfg_shift;
  logic cfg_greset;
  logic cfg_tail;

  modport master (output cfg_head, output cfg_shift, output cfg_greset, input cfg_tail);
  modport slave  (input cfg_head, input cfg_shift, input cfg_greset, output cfg_tail);
endinterface

// File: rtl/fcb_cfg_receiver.sv
// Fabric-side FCB configuration chain receiver with shadow commit.
// Optional Adler-32 over received bytes, enabled by CFG_CHAIN_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for global config reset to assert
// LOAD   | accepting bits, counting, assembling bytes
// FOLD   | one cycle: fold partial byte, commit chain and checksum
// ACTIVE | configuration valid; chain still shifts for readback
module fcb_cfg_receiver #(
  parameter int CHAIN_LEN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  fcb_cfg_receiver_if.slave    fcb,
  output logic [CHAIN_LEN-1:0] cfg_bits,
  output logic                 cfg_valid,
  output logic [31:0]          cfg_bit_count,
  output logic [31:0]          cfg_checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, FOLD, ACTIVE} state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] chain;
  logic                 chain_shift;

  assign chain_shift  = fcb.cfg_shift && (state == LOAD || state == ACTIVE);
  assign fcb.cfg_tail = chain[CHAIN_LEN-1];

`ifdef CFG_CHAIN_CHECKSUM_EN
  localparam logic [16:0] ADLER_MOD = 17'd65521;

  logic [7:0]  byte_reg;
  logic [2:0]  byte_cnt;
  logic [15:0] sum_a;
  logic [15:0] sum_b;
  logic [7:0]  byte_next;
  logic [7:0]  part_byte;
  logic [31:0] fold_full;
  logic [31:0] fold_part;
  logic [31:0] fold_final;

  // One conditional subtract per step is enough: both operands are below the modulus.
  function automatic logic [31:0] adler_fold(input logic [15:0] a, input logic [15:0] b,
                                             input logic [7:0] d);
    logic [16:0] a_n;
    logic [16:0] b_n;
    a_n = {1'b0, a} + {9'd0, d};
    if (a_n >= ADLER_MOD) a_n = a_n - ADLER_MOD;
    b_n = {1'b0, b} + a_n;
    if (b_n >= ADLER_MOD) b_n = b_n - ADLER_MOD;
    return {b_n[15:0], a_n[15:0]};
  endfunction

  assign byte_next  = {byte_reg[6:0], fcb.cfg_head};
  assign part_byte  = byte_reg & ((8'd1 << byte_cnt) - 8'd1);
  assign fold_full  = adler_fold(sum_a, sum_b, byte_next);
  assign fold_part  = adler_fold(sum_a, sum_b, part_byte);
  assign fold_final = (byte_cnt != 3'd0) ? fold_part : {sum_b, sum_a};
`else
  assign cfg_checksum = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      chain         <= '0;
      cfg_bits      <= '0;
      cfg_valid     <= 1'b0;
      cfg_bit_count <= 32'd0;
`ifdef CFG_CHAIN_CHECKSUM_EN
      byte_reg      <= 8'd0;
      byte_cnt      <= 3'd0;
      sum_a         <= 16'd1;
      sum_b         <= 16'd0;
      cfg_checksum  <= 32'd0;
`endif
    end else begin
      if (chain_shift) chain <= {chain[CHAIN_LEN-2:0], fcb.cfg_head};

      case (state)
        IDLE: begin
          if (fcb.cfg_greset) state <= LOAD;
        end
        LOAD: begin
          if (fcb.cfg_shift) begin
            if (cfg_bit_count != 32'hFFFF_FFFF) cfg_bit_count <= cfg_bit_count + 32'd1;
`ifdef CFG_CHAIN_CHECKSUM_EN
            byte_reg <= byte_next;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) {sum_b, sum_a} <= fold_full;
`endif
          end
          if (!fcb.cfg_greset) state <= FOLD;
        end
        FOLD: begin
          cfg_bits  <= chain;
          cfg_valid <= 1'b1;
`ifdef CFG_CHAIN_CHECKSUM_EN
          {sum_b, sum_a} <= fold_final;
          cfg_checksum   <= fold_final;
`endif
          state <= ACTIVE;
        end
        ACTIVE: begin
          // Re-entering LOAD restarts counting; the chain contents are kept.
          if (fcb.cfg_greset) begin
            state         <= LOAD;
            cfg_valid     <= 1'b0;
            cfg_bit_count <= 32'd0;
`ifdef CFG_CHAIN_CHECKSUM_EN
            byte_reg <= 8'd0;
            byte_cnt <= 3'd0;
            sum_a    <= 16'd1;
            sum_b    <= 16'd0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcb_cfg_receiver.sv
// Self-checking bench for fcb_cfg_receiver: spec vectors, corner sequences
// and randomized loads against a queue-based reference model.
module tb_fcb_cfg_receiver;
  localparam int CL = 64;
`ifdef CFG_CHAIN_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CL-1:0] cfg_bits;
  logic          cfg_valid;
  logic [31:0]   cfg_bit_count;
  logic [31:0]   cfg_checksum;

  fcb_cfg_receiver_if fcb();

  fcb_cfg_receiver #(.CHAIN_LEN(CL)) dut (
    .clk           (clk),
    .reset         (reset),
    .fcb           (fcb.slave),
    .cfg_bits      (cfg_bits),
    .cfg_valid     (cfg_valid),
    .cfg_bit_count (cfg_bit_count),
    .cfg_checksum  (cfg_checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CL-1:0] m_chain;
  logic [CL-1:0] m_committed;
  logic [31:0]   m_sum;
  int unsigned   m_count;
  bit            m_active;
  bit            m_load[$];
  bit            stim[$];
  int            gap_max;

  typedef struct {
    int          nbits;
    logic [63:0] data;
    bit          same_cycle;
    logic [31:0] exp_sum;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Adler-32 from the definition: bytes MSB-first, trailing partial byte right-aligned.
  function automatic logic [31:0] adler(input bit q[$]);
    int unsigned a = 1;
    int unsigned b = 0;
    int unsigned d;
    int nb = q.size() / 8;
    int k = q.size() % 8;
    for (int i = 0; i < nb; i++) begin
      d = 0;
      for (int j = 0; j < 8; j++) d = d * 2 + q[i*8+j];
      a = (a + d) % 65521;
      b = (b + a) % 65521;
    end
    if (k != 0) begin
      d = 0;
      for (int j = nb * 8; j < q.size(); j++) d = d * 2 + q[j];
      a = (a + d) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  function automatic void m_shift(input bit b);
    m_chain = {m_chain[CL-2:0], b};
  endfunction

  task automatic set_stim(input int n, input logic [63:0] data);
    stim.delete();
    for (int i = n - 1; i >= 0; i--) stim.push_back(data[i]);
  endtask

  // Enter LOAD (from IDLE or ACTIVE), shift stim, commit; checks commit results.
  task automatic do_load(input bit entry_shift, input bit entry_b, input bit same_cycle,
                         input bit fold_shift);
    bit sc;
    sc = same_cycle && (stim.size() > 0);
    fcb.cfg_greset = 1'b1;
    fcb.cfg_shift  = entry_shift;
    fcb.cfg_head   = entry_b;
    tick();
    if (m_active && entry_shift) m_shift(entry_b);
    m_active = 1'b0;
    m_count  = 0;
    m_load.delete();
    check("valid_low_in_load", cfg_valid, 0);
    for (int i = 0; i < stim.size(); i++) begin
      if (gap_max > 0 && $urandom_range(3) == 0) begin
        fcb.cfg_shift = 1'b0;
        fcb.cfg_head  = 1'($urandom);
        repeat ($urandom_range(1, gap_max)) tick();
      end
      fcb.cfg_head  = stim[i];
      fcb.cfg_shift = 1'b1;
      if (sc && i == stim.size() - 1) fcb.cfg_greset = 1'b0;
      tick();
      m_shift(stim[i]);
      m_count++;
      m_load.push_back(stim[i]);
      check("tail_load", fcb.cfg_tail, m_chain[CL-1]);
    end
    fcb.cfg_shift = 1'b0;
    if (!sc) begin
      fcb.cfg_greset = 1'b0;
      tick();
    end
    check("valid_low_in_fold", cfg_valid, 0);
    fcb.cfg_shift = fold_shift;
    fcb.cfg_head  = 1'b1;
    tick();
    fcb.cfg_shift = 1'b0;
    m_active    = 1'b1;
    m_committed = m_chain;
    m_sum       = CSUM_EN ? adler(m_load) : 32'd0;
    check("valid_high", cfg_valid, 1);
    check("bits_commit", cfg_bits, m_committed);
    check("bit_count", cfg_bit_count, m_count);
    check("checksum_model", cfg_checksum, m_sum);
    check("tail_after_commit", fcb.cfg_tail, m_chain[CL-1]);
  endtask

  task automatic active_shifts(input int n);
    for (int i = 0; i < n; i++) begin
      fcb.cfg_head  = 1'($urandom);
      fcb.cfg_shift = ($urandom_range(3) != 0);
      tick();
      if (fcb.cfg_shift) m_shift(fcb.cfg_head);
      check("tail_active", fcb.cfg_tail, m_chain[CL-1]);
      check("bits_frozen", cfg_bits, m_committed);
      check("count_frozen", cfg_bit_count, m_count);
      check("checksum_frozen", cfg_checksum, m_sum);
    end
    fcb.cfg_shift = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_chain  = '0;
    m_active = 1'b0;
    m_count  = 0;
  endtask

  initial begin
    logic [63:0] pat;
    logic [63:0] cap;

    vecs[0] = '{16, 64'h0102, 1'b0, 32'h00060004};
    vecs[1] = '{12, 64'hABC,  1'b0, 32'h016400B8};
    vecs[2] = '{8,  64'h01,   1'b1, 32'h00020002};
    vecs[3] = '{0,  64'h0,    1'b0, 32'h00000001};
    vecs[4] = '{64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h23E407F9};

    fcb.cfg_head   = 1'b0;
    fcb.cfg_shift  = 1'b0;
    fcb.cfg_greset = 1'b0;
    gap_max        = 0;
    m_committed    = '0;
    m_sum          = 32'd0;
    apply_reset();

    check("rst_tail", fcb.cfg_tail, 0);
    check("rst_bits", cfg_bits, 0);
    check("rst_valid", cfg_valid, 0);
    check("rst_count", cfg_bit_count, 0);
    check("rst_checksum", cfg_checksum, 0);

    // Shifts in IDLE are ignored.
    fcb.cfg_head  = 1'b1;
    fcb.cfg_shift = 1'b1;
    repeat (3) tick();
    fcb.cfg_shift = 1'b0;
    tick();
    check("idle_tail", fcb.cfg_tail, 0);
    check("idle_count", cfg_bit_count, 0);
    check("idle_valid", cfg_valid, 0);

    foreach (vecs[v]) begin
      set_stim(vecs[v].nbits, vecs[v].data);
      do_load(1'b0, 1'b0, vecs[v].same_cycle, 1'b0);
      check($sformatf("vec%0d_count", v), cfg_bit_count, vecs[v].nbits);
      check($sformatf("vec%0d_checksum", v), cfg_checksum, CSUM_EN ? vecs[v].exp_sum : 32'd0);
    end

    // Readback: pattern shifted back out through the tail in ACTIVE.
    pat = {$urandom, $urandom};
    set_stim(64, pat);
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    check("rb_bits", cfg_bits, pat);
    for (int j = 0; j < 64; j++) begin
      cap[63-j]     = fcb.cfg_tail;
      fcb.cfg_head  = 1'b0;
      fcb.cfg_shift = 1'b1;
      tick();
      m_shift(1'b0);
    end
    fcb.cfg_shift = 1'b0;
    check("rb_tail_pattern", cap, pat);
    check("rb_bits_kept", cfg_bits, pat);
    check("rb_count_kept", cfg_bit_count, 64);
    check("rb_valid", cfg_valid, 1);

    // Shift in the cycle greset rises from ACTIVE: chain moves, not counted.
    set_stim(8, 64'h01);
    do_load(1'b1, 1'b1, 1'b0, 1'b1);
    check("entry_count", cfg_bit_count, 8);
    check("entry_checksum", cfg_checksum, CSUM_EN ? 32'h00020002 : 32'd0);

    // 257 bytes of 0xFF: A passes 65521 and wraps.
    stim.delete();
    for (int i = 0; i < 257 * 8; i++) stim.push_back(1'b1);
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    check("ff_count", cfg_bit_count, 257 * 8);
    check("ff_checksum_a", cfg_checksum[15:0], CSUM_EN ? 16'h000F : 16'h0000);

    // Reset in LOAD after 20 bits.
    fcb.cfg_greset = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      fcb.cfg_head  = 1'($urandom);
      fcb.cfg_shift = 1'b1;
      tick();
    end
    fcb.cfg_shift = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_chain  = '0;
    m_active = 1'b0;
    check("midrst_tail", fcb.cfg_tail, 0);
    check("midrst_bits", cfg_bits, 0);
    check("midrst_valid", cfg_valid, 0);
    check("midrst_count", cfg_bit_count, 0);
    check("midrst_checksum", cfg_checksum, 0);
    set_stim(16, 64'h0102);
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_reload_checksum", cfg_checksum, CSUM_EN ? 32'h00060004 : 32'd0);
    check("midrst_reload_bits", cfg_bits, 64'h0102);

    // Randomized loads with gaps and corner-case strobes.
    gap_max = 3;
    for (int it = 0; it < 25; it++) begin
      stim.delete();
      repeat ($urandom_range(0, 150)) stim.push_back(1'($urandom));
      do_load(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      active_shifts($urandom_range(0, 20));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
